bcd_converter: RTL
==================

// Module: bcd_converter
// PURPOSE
//  AHB-Lite slave that converts a binary value to packed BCD with an iterative
//  double-dabble engine (one shift per cycle). Software writes a binary
//  speed/distance value, polls STATUS, reads RESULT and writes the BCD digits to
//  the seven-segment peripheral. Sits on the same AHB bus, directly upstream of
//  the display store registers.
// PARAMETERS
//  BIN_WIDTH  16  width of binary operand (1..24)
//  DIGITS     5   BCD digits in result; 10**DIGITS > 2**BIN_WIDTH-1, DIGITS<=8
// PORTS
//  HCLK       in   1   system clock, all state on rising edge
//  HRESET     in   1   asynchronous, active-high reset
//  HADDR      in   32  only HADDR[3:2] decoded
//  HWDATA     in   32  write data (data phase)
//  HWRITE     in   1   1=write, 0=read
//  HREADY     in   1   bus ready
//  HSEL       in   1   slave select
//  HSIZE      in   3   ignored (word access only)
//  HTRANS     in   2   transfer type; IDLE (2'b00) ignored
//  HRDATA     out  32  read data (data phase)
//  HREADYOUT  out  1   tied 1, zero wait states
// BEHAVIOUR
//  Bus: address phase is accepted when HSEL & HREADY & HTRANS!=0. On acceptance,
//   HWRITE, HADDR[3:2] and a valid flag are registered. The write/read takes
//   effect in the following data phase; the write is applied at the edge that
//   ends the data phase. The flags are cleared in any cycle with no accepted
//   transfer.
//  Map (HADDR[3:2]):
//   0 DATA_IN  W: HWDATA[BIN_WIDTH-1:0] -> operand, starts conversion
//              R: last accepted operand, zero-extended
//   1 RESULT   R: {0, DIGITS x 4-bit BCD, digit0 in [3:0]}; W: ignored
//   2 STATUS   R: bit0 BUSY, bit1 DONE, bit2 OVERRUN, others 0
//              W: any write clears DONE and OVERRUN
//   3 reserved R: 0; W: ignored
//  HRDATA is a combinational mux on the registered address during a read data
//   phase; it is 0 otherwise.
//  Reset: state=IDLE, operand=0, RESULT=0, work regs=0, BUSY=DONE=OVERRUN=0,
//   HRDATA=0, HREADYOUT=1. Asynchronous reset mid-conversion aborts it and does
//   not set DONE.
//  FSM:
//   IDLE -> CONV on a DATA_IN write edge (E0). At E0: load shift reg
//    {DIGITS*4'b0, operand}, count=0, BUSY=1.
//   CONV: on each edge, every BCD nibble >=5 gets +3 (nibble-wise, no carry
//    between nibbles), then the whole reg shifts left 1. count increments.
//   CONV -> IDLE on the BIN_WIDTH-th CONV edge (E16 at default). That edge
//    also latches the BCD field into RESULT, clears BUSY and sets DONE.
//  Latency: DONE visible to a read whose data phase follows E0+BIN_WIDTH edges.
//   Back-to-back conversion period = BIN_WIDTH+1 cycles.
//  DATA_IN write while BUSY=1 (including at the completing edge): operand,
//   conversion and RESULT are unchanged, and OVERRUN is set (sticky).
//  RESULT holds the previous result for the whole conversion and updates only
//   at completion.
//  STATUS write on the same edge that DONE sets: the set wins, so DONE=1.
//   OVERRUN set by a DATA_IN write on the same edge as a STATUS clear is not
//   possible, since there is one transfer per cycle.
//  Operand bits above BIN_WIDTH are ignored.
//  A DATA_IN write while DONE=1 starts a new conversion and clears DONE at E0.
// TESTING
//  1 reset mid-CONV (write 1234, assert HRESET at E5) -> STATUS=0, RESULT=0,
//    HRDATA=0, no DONE afterwards
//  2 write DATA_IN=0x04D2 -> BUSY for 16 cycles, then STATUS=0x2,
//    RESULT=0x01234; RESULT reads previous value while BUSY
//  3 write 0xFFFF -> RESULT=0x65535; write 0 -> RESULT=0x00000;
//    write 0x1_0009 -> RESULT=0x00009 (upper bits dropped)
//  4 write 100, then write 200 at E3 -> OVERRUN=1, RESULT=0x00100;
//    STATUS write -> STATUS=0
//  5 STATUS write with data phase ending on the completing edge -> DONE=1 after;
//    HTRANS=IDLE or HREADY=0 write to DATA_IN -> no conversion, HREADYOUT always 1
//  6 read reserved addr 3 and DATA_IN after write 0x04D2 -> 0 and 0x000004D2

Source files
------------

// File: rtl/bcd_converter.sv
// AHB-Lite slave: binary operand in, packed BCD out.
// Iterative double-dabble engine, one shift per clock.
module bcd_converter #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SW    = BCD_W + BIN_WIDTH;
    localparam int CW    = $clog2(BIN_WIDTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CONV = 1'b1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_RESULT = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;

    logic [0:0]           r_state;
    logic [BIN_WIDTH-1:0] r_operand;
    logic [BCD_W-1:0]     r_result;
    logic [SW-1:0]        r_shift;
    logic [CW-1:0]        r_count;
    logic                 r_done;
    logic                 r_overrun;

    logic                 r_dp_valid;
    logic                 r_dp_write;
    logic [1:0]           r_dp_addr;

    logic                 w_accept;
    logic                 w_wr_data;
    logic                 w_wr_status;
    logic                 w_rd;
    logic                 w_busy;
    logic                 w_last;
    logic [SW-1:0]        w_adj;
    logic [SW-1:0]        w_next;
    logic                 w_unused;

    assign HREADYOUT = 1'b1;

    assign w_accept    = HSEL & HREADY & (HTRANS != 2'b00);
    assign w_wr_data   = r_dp_valid & r_dp_write & (r_dp_addr == A_DATA);
    assign w_wr_status = r_dp_valid & r_dp_write & (r_dp_addr == A_STATUS);
    assign w_rd        = r_dp_valid & ~r_dp_write;

    assign w_busy = (r_state == S_CONV);
    assign w_last = (r_count == CW'(BIN_WIDTH - 1));

    assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0],
                        HWDATA[31:BIN_WIDTH]};

    // Address phase capture; flags drop whenever no transfer is accepted
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'b00;
        end else begin
            r_dp_valid <= w_accept;
            r_dp_write <= w_accept & HWRITE;
            r_dp_addr  <= w_accept ? HADDR[3:2] : 2'b00;
        end
    end

    // Nibble-wise +3 on every BCD digit >= 5, no carry between digits
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shift[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
                w_adj[BIN_WIDTH + 4*i +: 4] =
                    r_shift[BIN_WIDTH + 4*i +: 4] + 4'd3;
            end
        end
        w_next = {w_adj[SW-2:0], 1'b0};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_operand <= '0;
            r_result  <= '0;
            r_shift   <= '0;
            r_count   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_wr_data) begin
                        r_operand <= HWDATA[BIN_WIDTH-1:0];
                        r_shift   <= {{BCD_W{1'b0}}, HWDATA[BIN_WIDTH-1:0]};
                        r_count   <= '0;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift <= w_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_result <= w_next[SW-1 -: BCD_W];
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Completion set is last so it beats a same-edge STATUS clear
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_status) begin
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_wr_data && !w_busy) begin
                r_done <= 1'b0;
            end
            if (w_wr_data && w_busy) begin
                r_overrun <= 1'b1;
            end
            if (w_busy && w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (w_rd) begin
            case (r_dp_addr)
                A_DATA:   HRDATA = 32'(r_operand);
                A_RESULT: HRDATA = 32'(r_result);
                A_STATUS: HRDATA = {29'h0, r_overrun, r_done, w_busy};
                default:  HRDATA = 32'h0;
            endcase
        end
    end

endmodule
